// File: rtl/acsi_pkg.sv
// rtl/acsi_pkg.sv - shared states, status constants and opcode length decode for the ACSI initiator
package acsi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL_HI,
    ST_SEL_LO,
    ST_WAIT_IRQ,
    ST_STAT_HI,
    ST_STAT_LO,
    ST_DONE
  } acsi_state_t;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_SETUP,
    BC_HIGH
  } bc_state_t;

  localparam logic [7:0] REJECT_STATUS  = 8'h02;
  localparam logic [7:0] TIMEOUT_STATUS = 8'hff;
  localparam logic [4:0] ICD_ESC        = 5'h1f;

  // Command length from the SCSI group code (opcode[7:5]); 0 marks an unsupported group.
  function automatic logic [4:0] cmd_len(input logic [2:0] group);
    case (group)
      3'd0:       cmd_len = 5'd6;
      3'd1, 3'd2: cmd_len = 5'd10;
      3'd4:       cmd_len = 5'd16;
      3'd5:       cmd_len = 5'd12;
      default:    cmd_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/acsi_bus_cycle.sv
// rtl/acsi_bus_cycle.sv - one ACSI select access: set up a1/rw/dout, hold sel for SEL_TICKS ticks, capture din
module acsi_bus_cycle
  import acsi_pkg::*;
#(
  parameter int SEL_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       go,
  input  logic       a1_in,
  input  logic       rw_in,
  input  logic [7:0] dout_in,
  input  logic [7:0] din,
  output logic       acsi_a1,
  output logic       acsi_sel,
  output logic       acsi_rw,
  output logic [7:0] acsi_dout,
  output logic [7:0] din_q,
  output logic       done
);

  localparam logic [7:0] LAST_TICK = 8'(SEL_TICKS - 1);

  bc_state_t  st;
  logic [7:0] tick_cnt;

  // Address/data are latched on go and only change again at the next go, so
  // they lead the sel rising edge by at least one clk and outlast its fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= BC_IDLE;
      acsi_a1   <= 1'b0;
      acsi_sel  <= 1'b0;
      acsi_rw   <= 1'b1;
      acsi_dout <= 8'h00;
      din_q     <= 8'h00;
      done      <= 1'b0;
      tick_cnt  <= 8'h00;
    end else begin
      done <= 1'b0;
      case (st)
        BC_IDLE: begin
          if (go) begin
            acsi_a1   <= a1_in;
            acsi_rw   <= rw_in;
            acsi_dout <= dout_in;
            st        <= BC_SETUP;
          end
        end
        BC_SETUP: begin
          if (clk_en) begin
            acsi_sel <= 1'b1;
            tick_cnt <= 8'h00;
            st       <= BC_HIGH;
          end
        end
        BC_HIGH: begin
          if (clk_en) begin
            if (tick_cnt == LAST_TICK) begin
              acsi_sel <= 1'b0;
              din_q    <= din;
              done     <= 1'b1;
              st       <= BC_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 8'h01;
            end
          end
        end
        default: st <= BC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/acsi_initiator.sv
// rtl/acsi_initiator.sv - ACSI command sequencer top; define ACSI_ICD_EN to send opcodes >= 0x20 via the ICD escape
module acsi_initiator
  import acsi_pkg::*;
#(
  parameter int          SEL_TICKS = 2,
  parameter logic [23:0] TIMEOUT   = 24'd2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       cmd_wr,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       start,
  input  logic [2:0] cmd_target,
  output logic       busy,
  output logic       done,
  output logic [7:0] status,
  output logic       err,
  output logic       timeout,
  output logic       acsi_a1,
  output logic       acsi_sel,
  output logic       acsi_rw,
  output logic [7:0] acsi_dout,
  input  logic [7:0] acsi_din,
  input  logic       acsi_irq
);

  logic [7:0]  cmd_buf [16];
  acsi_state_t state;
  logic        icd_q;
  logic [4:0]  idx;
  logic [4:0]  last_idx;
  logic [23:0] tcnt;
  logic [7:0]  status_cap;

  logic        go;
  logic        bc_a1;
  logic        bc_rw;
  logic [7:0]  bc_dout;
  logic        bc_done;
  logic [7:0]  bc_din;

  logic [7:0]  op_now;
  logic [4:0]  start_len;
  logic [4:0]  start_last;
  logic        start_icd;
  logic [7:0]  next_byte;

  always_ff @(posedge clk) begin
    if (cmd_wr && !busy) cmd_buf[cmd_addr] <= cmd_data;
  end

  // A write to byte 0 in the start cycle must steer the length decode.
  assign op_now = (cmd_wr && cmd_addr == 4'd0) ? cmd_data : cmd_buf[0];

`ifdef ACSI_ICD_EN
  assign start_len = cmd_len(op_now[7:5]);
  assign start_icd = (op_now >= 8'h20);
`else
  assign start_len = (op_now < 8'h20) ? cmd_len(op_now[7:5]) : 5'd0;
  assign start_icd = 1'b0;
`endif

  // ICD sends the escape first, so bus byte k carries buffer[k-1].
  assign start_last = start_icd ? start_len : start_len - 5'd1;
  assign next_byte  = cmd_buf[icd_q ? idx[3:0] : idx[3:0] + 4'd1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= 8'h00;
      err        <= 1'b0;
      timeout    <= 1'b0;
      icd_q      <= 1'b0;
      idx        <= 5'd0;
      last_idx   <= 5'd0;
      tcnt       <= 24'd0;
      status_cap <= 8'h00;
      go         <= 1'b0;
      bc_a1      <= 1'b0;
      bc_rw      <= 1'b1;
      bc_dout    <= 8'h00;
    end else begin
      done <= 1'b0;
      go   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !done) begin
            if (start_len == 5'd0) begin
              status  <= REJECT_STATUS;
              err     <= 1'b1;
              timeout <= 1'b0;
              done    <= 1'b1;
            end else begin
              busy     <= 1'b1;
              icd_q    <= start_icd;
              idx      <= 5'd0;
              last_idx <= start_last;
              go       <= 1'b1;
              bc_a1    <= 1'b0;
              bc_rw    <= 1'b0;
              bc_dout  <= {cmd_target, start_icd ? ICD_ESC : op_now[4:0]};
              state    <= ST_SEL_HI;
            end
          end
        end
        ST_SEL_HI: begin
          if (bc_done) state <= ST_SEL_LO;
        end
        ST_SEL_LO: begin
          if (clk_en) begin
            tcnt  <= 24'd0;
            state <= ST_WAIT_IRQ;
          end
        end
        ST_WAIT_IRQ: begin
          if (clk_en) begin
            if (acsi_irq) begin
              go    <= 1'b1;
              bc_a1 <= 1'b1;
              if (idx == last_idx) begin
                bc_rw   <= 1'b1;
                bc_dout <= 8'h00;
                state   <= ST_STAT_HI;
              end else begin
                idx     <= idx + 5'd1;
                bc_rw   <= 1'b0;
                bc_dout <= next_byte;
                state   <= ST_SEL_HI;
              end
            end else if (tcnt == TIMEOUT - 24'd1) begin
              status  <= TIMEOUT_STATUS;
              err     <= 1'b1;
              timeout <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              tcnt <= tcnt + 24'd1;
            end
          end
        end
        ST_STAT_HI: begin
          if (bc_done) begin
            status_cap <= bc_din;
            state      <= ST_STAT_LO;
          end
        end
        ST_STAT_LO: begin
          if (clk_en) state <= ST_DONE;
        end
        ST_DONE: begin
          status  <= status_cap;
          err     <= status_cap[1];
          timeout <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  acsi_bus_cycle #(
    .SEL_TICKS(SEL_TICKS)
  ) u_bus_cycle (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .go       (go),
    .a1_in    (bc_a1),
    .rw_in    (bc_rw),
    .dout_in  (bc_dout),
    .din      (acsi_din),
    .acsi_a1  (acsi_a1),
    .acsi_sel (acsi_sel),
    .acsi_rw  (acsi_rw),
    .acsi_dout(acsi_dout),
    .din_q    (bc_din),
    .done     (bc_done)
  );

endmodule

// File: tb/tb_acsi_initiator.sv
// tb/tb_acsi_initiator.sv - scoreboard bench for acsi_initiator with a small IRQ-driven target model
module tb_acsi_initiator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic       cmd_wr = 1'b0;
  logic [3:0] cmd_addr = 4'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       start = 1'b0;
  logic [2:0] cmd_target = 3'd0;
  logic       busy, done, err, timeout;
  logic [7:0] status;
  logic       acsi_a1, acsi_sel, acsi_rw;
  logic [7:0] acsi_dout;
  logic [7:0] acsi_din;
  logic       acsi_irq = 1'b0;

  logic [7:0] tgt_status = 8'h00;
  logic       tgt_en = 1'b1;
  int         tgt_delay = 6;
  int         irq_cnt = -1;

  logic [9:0] exp_wr [$];
  logic [9:0] exp_res [$];
  logic [7:0] vec [16];
  int         vlen;
  int         n_checks = 0;
  int         n_errors = 0;
  int         sel_edges = 0;
  int         done_seen = 0;
  int         base, e0;

  assign acsi_din = tgt_status;

  acsi_initiator #(
    .SEL_TICKS(2),
    .TIMEOUT  (24'd40)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .start     (start),
    .cmd_target(cmd_target),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .err       (err),
    .timeout   (timeout),
    .acsi_a1   (acsi_a1),
    .acsi_sel  (acsi_sel),
    .acsi_rw   (acsi_rw),
    .acsi_dout (acsi_dout),
    .acsi_din  (acsi_din),
    .acsi_irq  (acsi_irq)
  );

  initial forever begin
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    clk_en = ~clk_en;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

  // Target model plus bus monitor: every select rising edge is checked against exp_wr.
  initial begin
    logic       sel_prev;
    logic [9:0] e, got, prev_bus;
    sel_prev = 1'b0;
    prev_bus = 10'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        acsi_irq = 1'b0;
        irq_cnt  = -1;
      end else if (acsi_sel && !sel_prev) begin
        sel_edges++;
        acsi_irq = 1'b0;
        irq_cnt  = tgt_en ? tgt_delay : -1;
        got = {acsi_a1, acsi_rw, acsi_dout};
        n_checks++;
        if (got !== prev_bus) begin
          n_errors++;
          $display("FAIL bus_setup: a1/rw/dout %h at sel rise, was %h one clk earlier", got, prev_bus);
        end
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_sel: a1=%0d rw=%0d dout=%h, expected no access", acsi_a1, acsi_rw, acsi_dout);
        end else begin
          e = exp_wr.pop_front();
          if (e[8]) begin
            got[7:0] = 8'h00;
            e[7:0]   = 8'h00;
          end
          n_checks++;
          if (got !== e) begin
            n_errors++;
            $display("FAIL bus_byte: got a1/rw/dout=%h expected %h", got, e);
          end
        end
      end else if (irq_cnt > 0) begin
        irq_cnt--;
      end else if (irq_cnt == 0) begin
        acsi_irq = 1'b1;
        irq_cnt  = -1;
      end
      sel_prev = acsi_sel;
      prev_bus = {acsi_a1, acsi_rw, acsi_dout};
    end
  end

  // Result monitor: each done pulse pops one expected {status, err, timeout}.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_seen++;
        n_checks++;
        if (exp_res.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_done: status=%h err=%0d timeout=%0d, expected no done", status, err, timeout);
        end else begin
          e = exp_res.pop_front();
          if ({status, err, timeout, busy, acsi_sel} !== {e, 2'b00}) begin
            n_errors++;
            $display("FAIL result: got status=%h err=%0d timeout=%0d busy=%0d sel=%0d expected status=%h err=%0d timeout=%0d busy=0 sel=0",
                     status, err, timeout, busy, acsi_sel, e[9:2], e[1], e[0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd_wr = 1'b1; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_wr = 1'b0;
  endtask

  task automatic load_vec();
    for (int i = 0; i < vlen; i++) wr_byte(4'(i), vec[i]);
  endtask

  task automatic set_vec(input logic [7:0] b0, b1, b2, b3, b4, b5, input int n);
    for (int i = 0; i < 16; i++) vec[i] = 8'h00;
    vec[0] = b0; vec[1] = b1; vec[2] = b2; vec[3] = b3; vec[4] = b4; vec[5] = b5;
    vlen = n;
  endtask

  task automatic push_seq(input logic [2:0] tgt, input logic icd, input logic [7:0] st);
    if (icd) begin
      exp_wr.push_back({2'b00, tgt, 5'h1f});
      exp_wr.push_back({2'b10, vec[0]});
    end else begin
      exp_wr.push_back({2'b00, tgt, vec[0][4:0]});
    end
    for (int i = 1; i < vlen; i++) exp_wr.push_back({2'b10, vec[i]});
    exp_wr.push_back({2'b11, 8'h00});
    exp_res.push_back({st, st[1], 1'b0});
  endtask

  task automatic pulse_start(input logic [2:0] tgt);
    @(negedge clk);
    start = 1'b1; cmd_target = tgt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int b, input int budget);
    int n;
    n = 0;
    while (done_seen == b && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_seen != b), 32'd1);
  endtask

  task automatic finish_case(input string name, input int b);
    repeat (20) @(negedge clk);
    chk({name, "_done_count"}, 32'(done_seen - b), 32'd1);
    chk({name, "_left_writes"}, 32'(exp_wr.size()), 32'd0);
    chk({name, "_left_results"}, 32'(exp_res.size()), 32'd0);
    chk({name, "_idle"}, {30'd0, busy, acsi_sel}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (4) @(negedge clk);
    chk("reset_state", {13'd0, busy, done, status, err, timeout, acsi_sel, acsi_a1, acsi_rw, acsi_dout},
        {13'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    reset = 1'b0;

    // TEST UNIT READY, target 0: first byte 00
    set_vec(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6);
    load_vec();
    base = done_seen; e0 = sel_edges;
    push_seq(3'd0, 1'b0, 8'h00);
    pulse_start(3'd0);
    wait_done("tur", base, 2000);
    finish_case("tur", base);
    chk("tur_sel_edges", 32'(sel_edges - e0), 32'd7);

    // INQUIRY, target 2: first byte 8'h52
    set_vec(8'h12, 8'h00, 8'h00, 8'h00, 8'h24, 8'h00, 6);
    load_vec();
    base = done_seen;
    push_seq(3'd2, 1'b0, 8'h00);
    pulse_start(3'd2);
    wait_done("inquiry", base, 2000);
    finish_case("inquiry", base);

    // READ(6) past the end of the image: target reports check condition
    set_vec(8'h08, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 6);
    load_vec();
    tgt_status = 8'h02;
    base = done_seen;
    push_seq(3'd0, 1'b0, 8'h02);
    pulse_start(3'd0);
    wait_done("read6", base, 2000);
    finish_case("read6", base);
    tgt_status = 8'h00;

    // Target 1 never answers: one write, then timeout
    set_vec(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6);
    load_vec();
    tgt_en = 1'b0;
    base = done_seen; e0 = sel_edges;
    exp_wr.push_back({2'b00, 8'h20});
    exp_res.push_back({8'hff, 1'b1, 1'b1});
    pulse_start(3'd1);
    wait_done("timeout", base, 2000);
    finish_case("timeout", base);
    chk("timeout_sel_edges", 32'(sel_edges - e0), 32'd1);
    tgt_en = 1'b1;

    // READ CAPACITY (10-byte group 1)
    set_vec(8'h25, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 10);
    load_vec();
    base = done_seen; e0 = sel_edges;
`ifdef ACSI_ICD_EN
    push_seq(3'd0, 1'b1, 8'h00);
    pulse_start(3'd0);
    wait_done("readcap", base, 4000);
    finish_case("readcap", base);
    chk("readcap_sel_edges", 32'(sel_edges - e0), 32'd12);
`else
    exp_res.push_back({8'h02, 1'b1, 1'b0});
    pulse_start(3'd0);
    chk("readcap_reject_latency", {31'd0, done}, 32'd1);
    finish_case("readcap", base);
    chk("readcap_sel_edges", 32'(sel_edges - e0), 32'd0);
`endif

    // Groups 3 and 6/7 are always rejected one clk after start
    for (int k = 0; k < 2; k++) begin
      set_vec(k == 0 ? 8'h60 : 8'hc0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      load_vec();
      base = done_seen; e0 = sel_edges;
      exp_res.push_back({8'h02, 1'b1, 1'b0});
      pulse_start(3'd0);
      chk("reject_latency", {31'd0, done}, 32'd1);
      finish_case("reject", base);
      chk("reject_sel_edges", 32'(sel_edges - e0), 32'd0);
    end

    // Opcode written in the start cycle; start and cmd_wr while busy are ignored
    set_vec(8'h03, 8'h00, 8'h00, 8'h00, 8'h12, 8'h00, 6);
    for (int i = 1; i < 6; i++) wr_byte(4'(i), vec[i]);
    base = done_seen;
    push_seq(3'd3, 1'b0, 8'h00);
    @(negedge clk);
    cmd_wr = 1'b1; cmd_addr = 4'd0; cmd_data = 8'h03; start = 1'b1; cmd_target = 3'd3;
    @(negedge clk);
    cmd_wr = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_running", {31'd0, busy}, 32'd1);
    wr_byte(4'd4, 8'haa);
    pulse_start(3'd5);
    wait_done("wr_start", base, 2000);
    finish_case("wr_start", base);

    // start in the same clk as done is ignored
    set_vec(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6);
    load_vec();
    base = done_seen; e0 = sel_edges;
    push_seq(3'd0, 1'b0, 8'h00);
    pulse_start(3'd0);
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen_for_overlap", {31'd0, done}, 32'd1);
    start = 1'b1; cmd_target = 3'd0;
    @(negedge clk);
    start = 1'b0;
    finish_case("start_on_done", base);
    chk("start_on_done_edges", 32'(sel_edges - e0), 32'd7);

    // Reset during the byte-3 select, then a clean rerun
    base = done_seen; e0 = sel_edges;
    push_seq(3'd0, 1'b0, 8'h00);
    pulse_start(3'd0);
    n = 0;
    while (!(sel_edges == e0 + 4 && acsi_sel) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_byte3", 32'(sel_edges - e0), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_seq", {29'd0, acsi_sel, busy, done}, 32'd0);
    reset = 1'b0;
    exp_wr.delete();
    exp_res.delete();
    repeat (20) @(negedge clk);
    chk("reset_no_done", 32'(done_seen - base), 32'd0);
    load_vec();
    base = done_seen; e0 = sel_edges;
    push_seq(3'd0, 1'b0, 8'h00);
    pulse_start(3'd0);
    wait_done("rerun", base, 2000);
    finish_case("rerun", base);
    chk("rerun_sel_edges", 32'(sel_edges - e0), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
